// File: rtl/matmul_pe_mac.sv
// matmul_pe_mac: output-stationary systolic PE, pipelined signed MAC with snapshot/shift drain.
// Define ACC_SAT_EN to make the accumulator saturate on overflow instead of wrapping.
module matmul_pe_mac #(
    parameter int DATA_W  = 16,
    parameter int ACC_W   = 40,
    parameter int MUL_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_acc,
    input  logic              a_valid_in,
    input  logic [DATA_W-1:0] a_in,
    input  logic              b_valid_in,
    input  logic [DATA_W-1:0] b_in,
    output logic              a_valid_out,
    output logic [DATA_W-1:0] a_out,
    output logic              b_valid_out,
    output logic [DATA_W-1:0] b_out,
    input  logic              snap,
    input  logic              shift_en,
    input  logic              c_valid_in,
    input  logic [ACC_W-1:0]  c_in,
    output logic              c_valid_out,
    output logic [ACC_W-1:0]  c_out,
    output logic              busy,
    output logic              acc_ovf
);
    localparam int PROD_W = 2 * DATA_W;

    logic              r_a_valid;
    logic [DATA_W-1:0] r_a;
    logic              r_b_valid;
    logic [DATA_W-1:0] r_b;
    logic [PROD_W-1:0] r_prod [MUL_LAT];
    logic [MUL_LAT-1:0] r_pv;
    logic [ACC_W-1:0]  r_acc;
    logic              r_ovf;
    logic              r_c_valid;
    logic [ACC_W-1:0]  r_c;

    logic [PROD_W-1:0] w_a_se;
    logic [PROD_W-1:0] w_b_se;
    logic [PROD_W-1:0] w_prod;
    logic [ACC_W-1:0]  w_prod_ext;
    logic [ACC_W-1:0]  w_addend;
    logic [ACC_W-1:0]  w_base;
    logic [ACC_W-1:0]  w_sum;
    logic [ACC_W-1:0]  w_acc_nxt;
    logic              w_ovf;

    // Operands are sign-extended to full product width so the low
    // PROD_W bits of the multiply are the exact signed product.
    assign w_a_se = {{DATA_W{a_in[DATA_W-1]}}, a_in};
    assign w_b_se = {{DATA_W{b_in[DATA_W-1]}}, b_in};
    assign w_prod = w_a_se * w_b_se;

    generate
        if (ACC_W > PROD_W) begin : g_ext
            assign w_prod_ext = {{(ACC_W - PROD_W){r_prod[MUL_LAT-1][PROD_W-1]}},
                                 r_prod[MUL_LAT-1]};
        end else begin : g_noext
            assign w_prod_ext = r_prod[MUL_LAT-1];
        end
    endgenerate

    assign w_addend = r_pv[MUL_LAT-1] ? w_prod_ext : '0;
    assign w_base   = clear_acc ? '0 : r_acc;
    assign w_sum    = w_base + w_addend;
    assign w_ovf    = (w_base[ACC_W-1] == w_addend[ACC_W-1]) &&
                      (w_sum[ACC_W-1] != w_base[ACC_W-1]);

`ifdef ACC_SAT_EN
    // Clamp toward the sign of the operands when the add overflows
    always_comb begin
        w_acc_nxt = w_sum;
        if (w_ovf) begin
            w_acc_nxt = w_base[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                        : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`else
    assign w_acc_nxt = w_sum;
`endif

    // Operand forwarding to right/bottom neighbours, unconditional
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_valid <= 1'b0;
            r_a       <= '0;
            r_b_valid <= 1'b0;
            r_b       <= '0;
        end else begin
            r_a_valid <= a_valid_in;
            r_a       <= a_in;
            r_b_valid <= b_valid_in;
            r_b       <= b_in;
        end
    end

    // Multiplier pipeline: product and its valid advance one stage per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pv <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                r_prod[i] <= '0;
            end
        end else begin
            r_pv[0]   <= a_valid_in & b_valid_in;
            r_prod[0] <= w_prod;
            for (int i = 1; i < MUL_LAT; i++) begin
                r_pv[i]   <= r_pv[i-1];
                r_prod[i] <= r_prod[i-1];
            end
        end
    end

    // Accumulator and sticky overflow; clear_acc restarts a tile without a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_acc <= w_acc_nxt;
            r_ovf <= clear_acc ? w_ovf : (r_ovf | w_ovf);
        end
    end

    // Drain register: snapshot of the old accumulator wins over chain shift
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_c_valid <= 1'b0;
            r_c       <= '0;
        end else if (snap) begin
            r_c_valid <= 1'b1;
            r_c       <= r_acc;
        end else if (shift_en) begin
            r_c_valid <= c_valid_in;
            r_c       <= c_in;
        end
    end

    assign a_valid_out = r_a_valid;
    assign a_out       = r_a;
    assign b_valid_out = r_b_valid;
    assign b_out       = r_b;
    assign c_valid_out = r_c_valid;
    assign c_out       = r_c;
    assign busy        = |r_pv;
    assign acc_ovf     = r_ovf;

endmodule

// File: tb/tb_matmul_pe_mac.sv
// tb_matmul_pe_mac: directed self-checking bench for matmul_pe_mac.
// Drain results are checked through an expected-value queue.
module tb_matmul_pe_mac;
    localparam int DATA_W  = 16;
    localparam int ACC_W   = 40;
    localparam int MUL_LAT = 3;
    localparam int ACC_S   = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clear_acc = 1'b0;
    logic              a_valid_in = 1'b0;
    logic [DATA_W-1:0] a_in = '0;
    logic              b_valid_in = 1'b0;
    logic [DATA_W-1:0] b_in = '0;
    logic              snap = 1'b0;
    logic              shift_en = 1'b0;
    logic              c_valid_in = 1'b0;
    logic [ACC_W-1:0]  c_in = '0;

    logic              a_valid_out;
    logic [DATA_W-1:0] a_out;
    logic              b_valid_out;
    logic [DATA_W-1:0] b_out;
    logic              c_valid_out;
    logic [ACC_W-1:0]  c_out;
    logic              busy;
    logic              acc_ovf;

    logic              s_a_valid_out;
    logic [DATA_W-1:0] s_a_out;
    logic              s_b_valid_out;
    logic [DATA_W-1:0] s_b_out;
    logic              s_c_valid_out;
    logic [ACC_S-1:0]  s_c_out;
    logic              s_busy;
    logic              s_acc_ovf;

    int checks   = 0;
    int failures = 0;

    logic [ACC_W-1:0] sb_q[$];
    logic [ACC_W-1:0] m_acc;
    logic [ACC_S-1:0] exp32;

    matmul_pe_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W), .MUL_LAT(MUL_LAT)) u_dut (
        .clk(clk), .rst(rst), .clear_acc(clear_acc),
        .a_valid_in(a_valid_in), .a_in(a_in),
        .b_valid_in(b_valid_in), .b_in(b_in),
        .a_valid_out(a_valid_out), .a_out(a_out),
        .b_valid_out(b_valid_out), .b_out(b_out),
        .snap(snap), .shift_en(shift_en),
        .c_valid_in(c_valid_in), .c_in(c_in),
        .c_valid_out(c_valid_out), .c_out(c_out),
        .busy(busy), .acc_ovf(acc_ovf)
    );

    matmul_pe_mac #(.DATA_W(DATA_W), .ACC_W(ACC_S), .MUL_LAT(MUL_LAT)) u_dut32 (
        .clk(clk), .rst(rst), .clear_acc(clear_acc),
        .a_valid_in(a_valid_in), .a_in(a_in),
        .b_valid_in(b_valid_in), .b_in(b_in),
        .a_valid_out(s_a_valid_out), .a_out(s_a_out),
        .b_valid_out(s_b_valid_out), .b_out(s_b_out),
        .snap(snap), .shift_en(shift_en),
        .c_valid_in(c_valid_in), .c_in(c_in[ACC_S-1:0]),
        .c_valid_out(s_c_valid_out), .c_out(s_c_out),
        .busy(s_busy), .acc_ovf(s_acc_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drain_chk(input string tag);
        logic [ACC_W-1:0] e;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=0x%0h expected=<queue empty>", tag, c_out);
        end else begin
            e = sb_q.pop_front();
            chk(tag, 64'(c_out), 64'(e));
            chk({tag, "_valid"}, 64'(c_valid_out), 64'd1);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-on reset
        repeat (2) step();
        rst = 1'b0;
        chk("rst_c_out", 64'(c_out), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ovf", 64'(acc_ovf), 64'd0);

        // Random traffic, then asynchronous reset in mid-cycle
        for (int i = 0; i < 4; i++) begin
            a_in       = 16'($urandom) | 16'h1;
            b_in       = 16'($urandom) | 16'h1;
            a_valid_in = 1'b1;
            b_valid_in = 1'b1;
            snap       = 1'($urandom);
            shift_en   = 1'b1;
            c_valid_in = 1'b1;
            c_in       = 40'($urandom) | 40'h1;
            step();
        end
        #2;
        rst = 1'b1;
        #1;
        chk("arst_a_out", 64'(a_out), 64'd0);
        chk("arst_a_valid", 64'(a_valid_out), 64'd0);
        chk("arst_b_out", 64'(b_out), 64'd0);
        chk("arst_b_valid", 64'(b_valid_out), 64'd0);
        chk("arst_c_out", 64'(c_out), 64'd0);
        chk("arst_c_valid", 64'(c_valid_out), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_ovf", 64'(acc_ovf), 64'd0);
        a_in = '0; b_in = '0; a_valid_in = 0; b_valid_in = 0;
        snap = 0; shift_en = 0; c_valid_in = 0; c_in = '0;
        repeat (2) step();
        rst = 1'b0;

        // Single MAC: 3 * -4
        a_in = 16'd3; b_in = 16'hFFFC; a_valid_in = 1; b_valid_in = 1;
        step();
        a_in = '0; b_in = '0; a_valid_in = 0; b_valid_in = 0;
        chk("fwd_a", 64'(a_out), 64'd3);
        chk("fwd_b", 64'(b_out), 64'hFFFC);
        chk("fwd_av", 64'(a_valid_out), 64'd1);
        chk("busy_e0", 64'(busy), 64'd1);
        step();
        chk("fwd_av_drop", 64'(a_valid_out), 64'd0);
        chk("busy_e1", 64'(busy), 64'd1);
        step();
        chk("busy_e2", 64'(busy), 64'd1);
        step();
        chk("busy_e3", 64'(busy), 64'd0);
        snap = 1;
        sb_q.push_back(40'(-12));
        step();
        snap = 0;
        drain_chk("single_mac");

        // Back-to-back stream, tile switch on the edge the last product lands
        m_acc = '0;
        for (int i = 1; i <= 5; i++) begin
            a_in = 16'(i); b_in = 16'(i);
            a_valid_in = 1; b_valid_in = 1;
            clear_acc = (i == 1);
            if (i < 5) m_acc = m_acc + 40'(i * i);
            step();
        end
        a_valid_in = 0; b_valid_in = 0; clear_acc = 0;
        a_in = '0; b_in = '0;
        repeat (2) step();
        snap = 1; clear_acc = 1;
        sb_q.push_back(m_acc);
        step();
        snap = 0; clear_acc = 0;
        drain_chk("stream_old_tile");
        chk("stream_busy", 64'(busy), 64'd0);
        snap = 1;
        sb_q.push_back(40'd25);
        step();
        snap = 0;
        drain_chk("stream_new_tile");

        // Only A valid: nothing issues, forwarding continues
        a_in = 16'd7; b_in = 16'd9; a_valid_in = 1; b_valid_in = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("onevalid_busy", 64'(busy), 64'd0);
            chk("onevalid_a", 64'(a_out), 64'd7);
            chk("onevalid_b", 64'(b_out), 64'd9);
            chk("onevalid_bv", 64'(b_valid_out), 64'd0);
        end
        a_valid_in = 0; a_in = '0; b_in = '0;
        snap = 1;
        sb_q.push_back(40'd25);
        step();
        snap = 0;
        drain_chk("onevalid_acc");

        // Drain chain shift, hold and snap priority
        c_in = 40'h123; c_valid_in = 1; shift_en = 1;
        sb_q.push_back(40'h123);
        step();
        drain_chk("shift_in");
        c_in = 40'h456; c_valid_in = 0;
        step();
        chk("shift_inv", 64'(c_out), 64'h456);
        chk("shift_inv_v", 64'(c_valid_out), 64'd0);
        shift_en = 0; c_in = 40'h789; c_valid_in = 1;
        step();
        chk("hold", 64'(c_out), 64'h456);
        chk("hold_v", 64'(c_valid_out), 64'd0);
        snap = 1; shift_en = 1;
        sb_q.push_back(40'd25);
        step();
        snap = 0; shift_en = 0; c_valid_in = 0; c_in = '0;
        drain_chk("snap_over_shift");

        // Overflow on the 32-bit accumulator, none on the 40-bit one
        a_in = 16'h7FFF; b_in = 16'h7FFF; a_valid_in = 1; b_valid_in = 1;
        clear_acc = 1;
        step();
        clear_acc = 0;
        repeat (2) step();
        a_valid_in = 0; b_valid_in = 0; a_in = '0; b_in = '0;
        repeat (2) step();
        chk("ovf32_two_adds", 64'(s_acc_ovf), 64'd0);
        step();
        chk("ovf32_third_add", 64'(s_acc_ovf), 64'd1);
        chk("ovf40_none", 64'(acc_ovf), 64'd0);
`ifdef ACC_SAT_EN
        exp32 = 32'h7FFFFFFF;
`else
        exp32 = 32'hBFFD0003;
`endif
        snap = 1;
        sb_q.push_back(40'h00BFFD0003);
        step();
        snap = 0;
        drain_chk("acc40_sum");
        chk("acc32_sum", 64'(s_c_out), 64'(exp32));
        chk("ovf32_sticky", 64'(s_acc_ovf), 64'd1);
        clear_acc = 1;
        step();
        clear_acc = 0;
        chk("ovf32_cleared", 64'(s_acc_ovf), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
